// File: rtl/dual_master_bus_arbiter_if.sv
// Bus-side signal bundle for dual_master_bus_arbiter: master requests and split
// control toward the arbiter, grants, ownership and split status back out.
interface dual_master_bus_arbiter_if;
    logic       m1_request;
    logic       m2_request;
    logic       slave_split;
    logic       split_resume;
    logic       split_resume_id;
    logic       m1_grant;
    logic       m2_grant;
    logic [1:0] bus_owner;
    logic       m1_split_pending;
    logic       m2_split_pending;
    logic [1:0] arb_state;

    // The arbiter takes the master modport; the requesting side takes slave.
    modport master (
        input  m1_request, m2_request, slave_split, split_resume, split_resume_id,
        output m1_grant, m2_grant, bus_owner, m1_split_pending, m2_split_pending, arb_state
    );

    modport slave (
        output m1_request, m2_request, slave_split, split_resume, split_resume_id,
        input  m1_grant, m2_grant, bus_owner, m1_split_pending, m2_split_pending, arb_state
    );
endinterface

// File: rtl/dual_master_bus_arbiter.sv
// Two-master bus arbiter with split/resume parking, tenure limit and turnaround gap.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties toward the least recently granted master.
module dual_master_bus_arbiter #(
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input logic                       clk,
    input logic                       reset,
    dual_master_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M1 = 2'd1,
        GRANT_M2 = 2'd2,
        TURN     = 2'd3
    } arbState_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURNAROUND - 1);

    arbState_t  state_q;
    logic [7:0] holdCount_q;
    logic [1:0] turnCount_q;
    logic       m1Pend_q, m2Pend_q, m1Pend_d, m2Pend_d;
    logic       m1ResPri_q, m2ResPri_q, m1ResPri_d, m2ResPri_d;
    logic       yieldM1_q, yieldM2_q;
    logic       m1Grant_q, m2Grant_q;
    logic [1:0] busOwner_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic       lastOwnerM2_q;
`endif

    logic eff1, eff2, resume1, resume2, split1, split2;
    logic preempt1, preempt2, release1, release2;
    logic tieToM1, pickM1, pickM2;

    always_comb begin
        eff1     = bus.m1_request & ~m1Pend_q;
        eff2     = bus.m2_request & ~m2Pend_q;
        resume1  = bus.split_resume & ~bus.split_resume_id;
        resume2  = bus.split_resume & bus.split_resume_id;
        split1   = (state_q == GRANT_M1) & bus.slave_split;
        split2   = (state_q == GRANT_M2) & bus.slave_split;
        preempt1 = (state_q == GRANT_M1) & (holdCount_q >= HOLD_LAST) & eff2;
        preempt2 = (state_q == GRANT_M2) & (holdCount_q >= HOLD_LAST) & eff1;
        release1 = (state_q == GRANT_M1) & (~bus.m1_request | bus.slave_split | preempt1);
        release2 = (state_q == GRANT_M2) & (~bus.m2_request | bus.slave_split | preempt2);

`ifdef ARB_ROUND_ROBIN_EN
        tieToM1 = lastOwnerM2_q;
`else
        tieToM1 = 1'b1;
`endif
        // A master just preempted for tenure yields the following tie so the bus hands over.
        if (yieldM1_q) begin
            tieToM1 = 1'b0;
        end else if (yieldM2_q) begin
            tieToM1 = 1'b1;
        end

        pickM1 = eff1 & (m1ResPri_q | (~(m2ResPri_q & eff2) & (~eff2 | tieToM1)));
        pickM2 = eff2 & ~pickM1;

        // A resume landing on the same edge as a split cancels it.
        m1Pend_d   = (m1Pend_q | split1) & ~resume1;
        m2Pend_d   = (m2Pend_q | split2) & ~resume2;
        m1ResPri_d = m1ResPri_q | (resume1 & (m1Pend_q | split1));
        m2ResPri_d = m2ResPri_q | (resume2 & (m2Pend_q | split2));
        if ((state_q == IDLE) && pickM1) begin
            m1ResPri_d = 1'b0;
        end
        if ((state_q == IDLE) && pickM2) begin
            m2ResPri_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            holdCount_q   <= '0;
            turnCount_q   <= '0;
            m1Pend_q      <= 1'b0;
            m2Pend_q      <= 1'b0;
            m1ResPri_q    <= 1'b0;
            m2ResPri_q    <= 1'b0;
            yieldM1_q     <= 1'b0;
            yieldM2_q     <= 1'b0;
            m1Grant_q     <= 1'b0;
            m2Grant_q     <= 1'b0;
            busOwner_q    <= 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
            lastOwnerM2_q <= 1'b1;
`endif
        end else begin
            m1Pend_q   <= m1Pend_d;
            m2Pend_q   <= m2Pend_d;
            m1ResPri_q <= m1ResPri_d;
            m2ResPri_q <= m2ResPri_d;
            case (state_q)
                IDLE: begin
                    if (pickM1 | pickM2) begin
                        state_q       <= pickM1 ? GRANT_M1 : GRANT_M2;
                        m1Grant_q     <= pickM1;
                        m2Grant_q     <= pickM2;
                        busOwner_q    <= pickM1 ? 2'd1 : 2'd2;
                        holdCount_q   <= '0;
                        yieldM1_q     <= 1'b0;
                        yieldM2_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        lastOwnerM2_q <= pickM2;
`endif
                    end
                end
                GRANT_M1, GRANT_M2: begin
                    if (release1 | release2) begin
                        state_q     <= (TURNAROUND == 0) ? IDLE : TURN;
                        turnCount_q <= '0;
                        m1Grant_q   <= 1'b0;
                        m2Grant_q   <= 1'b0;
                        busOwner_q  <= 2'd0;
                        yieldM1_q   <= preempt1;
                        yieldM2_q   <= preempt2;
                    end else if (holdCount_q != 8'hFF) begin
                        holdCount_q <= holdCount_q + 8'd1;
                    end
                end
                TURN: begin
                    if (turnCount_q == TURN_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        turnCount_q <= turnCount_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m1_grant         = m1Grant_q;
    assign bus.m2_grant         = m2Grant_q;
    assign bus.bus_owner        = busOwner_q;
    assign bus.m1_split_pending = m1Pend_q;
    assign bus.m2_split_pending = m2Pend_q;
    assign bus.arb_state        = state_q;
endmodule

// File: tb/tb_dual_master_bus_arbiter.sv
// Directed scoreboard bench for dual_master_bus_arbiter (MAX_HOLD=16, TURNAROUND=1);
// expectations follow ARB_ROUND_ROBIN_EN where the tie-break differs.
module tb_dual_master_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   failCount  = 0;

    typedef struct {
        string      tag;
        logic [7:0] vec;
    } expItem_t;

    expItem_t sbQueue[$];

    dual_master_bus_arbiter_if bus ();

    dual_master_bus_arbiter #(
        .MAX_HOLD  (16),
        .TURNAROUND(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected output vector {m1_grant, m2_grant, bus_owner, m1_pend, m2_pend, arb_state}.
    function automatic logic [7:0] expVec(input logic [1:0] st, input logic p1, input logic p2);
        logic [1:0] owner;
        owner = (st == 2'd1) ? 2'd1 : ((st == 2'd2) ? 2'd2 : 2'd0);
        return {st == 2'd1, st == 2'd2, owner, p1, p2, st};
    endfunction

    task automatic pushExpected(input string tag, input logic [1:0] st, input logic p1, input logic p2);
        expItem_t item;
        item.tag = tag;
        item.vec = expVec(st, p1, p2);
        sbQueue.push_back(item);
    endtask

    task automatic applyStimulus(input logic r1, input logic r2, input logic sp, input logic rs,
                                 input logic rid, input string tag, input logic [1:0] st,
                                 input logic p1, input logic p2);
        @(negedge clk);
        bus.m1_request      = r1;
        bus.m2_request      = r2;
        bus.slave_split     = sp;
        bus.split_resume    = rs;
        bus.split_resume_id = rid;
        pushExpected(tag, st, p1, p2);
    endtask

    task automatic checkOutput(input bit waitEdge);
        expItem_t   item;
        logic [7:0] actual;
        if (waitEdge) begin
            @(posedge clk);
            #1;
        end
        actual = {bus.m1_grant, bus.m2_grant, bus.bus_owner,
                  bus.m1_split_pending, bus.m2_split_pending, bus.arb_state};
        checkCount++;
        if (sbQueue.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_empty: observed %b, no expected entry", actual);
        end else begin
            item = sbQueue.pop_front();
            assert (actual === item.vec) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %b expected %b", item.tag, actual, item.vec);
            end
        end
    endtask

    task automatic cyc(input logic r1, input logic r2, input logic sp, input logic rs,
                       input logic rid, input string tag, input logic [1:0] st,
                       input logic p1, input logic p2);
        applyStimulus(r1, r2, sp, rs, rid, tag, st, p1, p2);
        checkOutput(1'b1);
    endtask

    initial begin
        reset               = 1'b1;
        bus.m1_request      = 1'b0;
        bus.m2_request      = 1'b0;
        bus.slave_split     = 1'b0;
        bus.split_resume    = 1'b0;
        bus.split_resume_id = 1'b0;
        #3 reset = 1'b0;
        #2;
        pushExpected("reset_init", 2'd0, 1'b0, 1'b0);
        checkOutput(1'b0);
        @(negedge clk);
        reset = 1'b1;

        // First tie after reset goes to m1 in both modes; m2 follows one TURN cycle after release.
        cyc(1, 1, 0, 0, 0, "tie1_grant",    2'd1, 0, 0);
        cyc(1, 1, 0, 0, 0, "tie1_hold",     2'd1, 0, 0);
        cyc(0, 1, 0, 0, 0, "m1_release",    2'd3, 0, 0);
        cyc(0, 1, 0, 0, 0, "turn_to_idle",  2'd0, 0, 0);
        cyc(0, 1, 0, 0, 0, "m2_after_turn", 2'd2, 0, 0);
        cyc(0, 0, 0, 0, 0, "m2_release",    2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "idle_a",        2'd0, 0, 0);

        cyc(1, 0, 0, 0, 0, "m1_alone",      2'd1, 0, 0);
        cyc(0, 0, 0, 0, 0, "m1_drop",       2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "turn_one",      2'd0, 0, 0);

`ifdef ARB_ROUND_ROBIN_EN
        cyc(1, 1, 0, 0, 0, "tie2_rr",       2'd2, 0, 0);
`else
        cyc(1, 1, 0, 0, 0, "tie2_fixed",    2'd1, 0, 0);
`endif
        cyc(0, 0, 0, 0, 0, "tie2_release",  2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "idle_c",        2'd0, 0, 0);

        // Tenure limit: m1 holds while m2 waits, is cut after 16 grant cycles.
        cyc(1, 1, 0, 0, 0, "hold_start",    2'd1, 0, 0);
        for (int i = 1; i < 16; i++) begin
            cyc(1, 1, 0, 0, 0, "hold_m1",   2'd1, 0, 0);
        end
        cyc(1, 1, 0, 0, 0, "preempt_m1",    2'd3, 0, 0);
        cyc(1, 1, 0, 0, 0, "preempt_idle",  2'd0, 0, 0);
        cyc(1, 1, 0, 0, 0, "m2_after_preempt", 2'd2, 0, 0);
        cyc(1, 1, 0, 0, 0, "m2_tenure",     2'd2, 0, 0);
        cyc(1, 0, 0, 0, 0, "m2_release_d",  2'd3, 0, 0);
        cyc(1, 0, 0, 0, 0, "idle_d",        2'd0, 0, 0);
        cyc(1, 0, 0, 0, 0, "m1_regrant",    2'd1, 0, 0);
        cyc(0, 0, 0, 0, 0, "m1_release_d",  2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "idle_d2",       2'd0, 0, 0);

        // Split m1, m2 takes over, resume m1 during m2 tenure; m1 wins the next tie.
        cyc(1, 0, 0, 0, 0, "m1_grant_e",    2'd1, 0, 0);
        cyc(1, 1, 1, 0, 0, "split_m1",      2'd3, 1, 0);
        cyc(1, 1, 0, 0, 0, "idle_m1_parked", 2'd0, 1, 0);
        cyc(1, 1, 0, 0, 0, "m2_while_parked", 2'd2, 1, 0);
        cyc(1, 1, 0, 1, 0, "resume_m1",     2'd2, 0, 0);
        cyc(1, 0, 0, 0, 0, "m2_release_e",  2'd3, 0, 0);
        cyc(1, 1, 0, 0, 0, "idle_e",        2'd0, 0, 0);
        cyc(1, 1, 0, 0, 0, "m1_resume_prio", 2'd1, 0, 0);
        cyc(0, 1, 0, 0, 0, "m1_release_e",  2'd3, 0, 0);
        cyc(0, 1, 0, 0, 0, "idle_e2",       2'd0, 0, 0);
        cyc(0, 1, 0, 0, 0, "m2_grant_e",    2'd2, 0, 0);
        cyc(0, 0, 0, 0, 0, "m2_release_e2", 2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "idle_e3",       2'd0, 0, 0);

        // Resumed m2 beats m1 on a tie even under fixed priority.
        cyc(0, 1, 0, 0, 0, "m2_grant_f",    2'd2, 0, 0);
        cyc(1, 1, 1, 0, 0, "split_m2",      2'd3, 0, 1);
        cyc(1, 1, 0, 0, 0, "idle_m2_parked", 2'd0, 0, 1);
        cyc(1, 1, 0, 0, 0, "m1_while_parked", 2'd1, 0, 1);
        cyc(1, 1, 0, 1, 1, "resume_m2",     2'd1, 0, 0);
        cyc(0, 1, 0, 0, 0, "m1_release_f",  2'd3, 0, 0);
        cyc(1, 1, 0, 0, 0, "idle_f",        2'd0, 0, 0);
        cyc(1, 1, 0, 0, 0, "m2_resume_prio", 2'd2, 0, 0);

        // Park both masters; bus stays idle until m2 is resumed.
        cyc(1, 1, 1, 0, 0, "split_m2_again", 2'd3, 0, 1);
        cyc(1, 1, 0, 0, 0, "idle_f2",       2'd0, 0, 1);
        cyc(1, 1, 0, 0, 0, "m1_grant_f",    2'd1, 0, 1);
        cyc(1, 1, 1, 0, 0, "split_m1_f",    2'd3, 1, 1);
        cyc(1, 1, 0, 0, 0, "idle_f3",       2'd0, 1, 1);
        cyc(1, 1, 0, 0, 0, "both_parked",   2'd0, 1, 1);
        cyc(1, 1, 0, 0, 0, "both_parked2",  2'd0, 1, 1);
        cyc(1, 1, 0, 1, 1, "resume_m2_idle", 2'd0, 1, 0);
        cyc(1, 1, 0, 0, 0, "m2_after_resume", 2'd2, 1, 0);
        cyc(1, 1, 0, 1, 1, "resume_ignored", 2'd2, 1, 0);
        cyc(1, 1, 1, 1, 1, "split_resume_same", 2'd3, 1, 0);
        cyc(1, 1, 0, 0, 0, "idle_f4",       2'd0, 1, 0);
        cyc(1, 1, 0, 0, 0, "m2_regrant_f",  2'd2, 1, 0);

        // Async reset in the middle of an m2 tenure.
        @(negedge clk);
        reset = 1'b0;
        #1;
        pushExpected("reset_mid_grant", 2'd0, 1'b0, 1'b0);
        checkOutput(1'b0);
        bus.m1_request   = 1'b0;
        bus.m2_request   = 1'b0;
        bus.slave_split  = 1'b0;
        bus.split_resume = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, "m1_after_reset", 2'd1, 0, 0);
        cyc(0, 0, 0, 0, 0, "m1_release_g",  2'd3, 0, 0);
        cyc(0, 0, 0, 0, 0, "idle_g",        2'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/dual_master_bus_arbiter.md
Name: dual_master_bus_arbiter

Overview:
- Arbitrates the shared serial bus between master 1 and master 2. Issues registered, mutually exclusive grants.
- Supports split transactions: a slave can park the current owner and later resume it. Enforces a maximum bus tenure.
- Sits between the two master interfaces and the slave-side split logic. Replaces direct enable sequencing by the test controller.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one master may hold a grant while the other master is requesting (legal 2..255).
- TURNAROUND, 1, idle cycles inserted between any grant release and the next grant (legal 0..3).

Ports:
- clk  input  1  bus clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m1_request  input  1  master 1 bus request; held high until the transaction completes.
- m2_request  input  1  master 2 bus request; held high until the transaction completes.
- slave_split  input  1  one-cycle pulse from the addressed slave: split the current owner's transaction.
- split_resume  input  1  one-cycle pulse: the slave is ready to complete a split transaction.
- split_resume_id  input  1  master targeted by split_resume (0 = m1, 1 = m2).
- m1_grant  output  1  master 1 owns the bus.
- m2_grant  output  1  master 2 owns the bus.
- bus_owner  output  2  0 = none, 1 = m1, 2 = m2.
- m1_split_pending  output  1  master 1 is parked on a split.
- m2_split_pending  output  1  master 2 is parked on a split.
- arb_state  output  2  current FSM state, for debug and the test controller.

Behaviour:
- Reset (async, active-low):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE; hold and turnaround counters clear; both split flags clear.
- FSM states: IDLE=0, GRANT_M1=1, GRANT_M2=2, TURN=3.
- Effective request:
  - eff_mN = mN_request AND NOT mN_split_pending.
  - A resumed master (split_resume seen for it) is "resume-priority" until it is next granted.
- IDLE:
  - Evaluated every cycle. Next state is GRANT_M1 or GRANT_M2, or stays IDLE.
  - Priority order: resume-priority master first; then fixed m1 over m2 (see optional feature).
  - Grant appears the cycle after the request is sampled (latency 1).
- GRANT_Mx:
  - mx_grant=1 and bus_owner=x. The hold counter increments every cycle, saturating at 255.
  - Exit to TURN on any of:
    - mx_request drops (normal release);
    - slave_split is high: set mx_split_pending the same edge;
    - hold counter reaches MAX_HOLD−1 while the other master's eff request is high (preemption).
  - If slave_split and a request drop happen together, treat it as a split.
- TURN:
  - Grants are 0. Wait TURNAROUND cycles, then go to IDLE.
  - If TURNAROUND=0, GRANT goes directly to IDLE evaluation: a new grant can be issued on the cycle following release.
- Split resume:
  - split_resume clears the pending flag of split_resume_id, in any state, and sets that master's resume-priority.
  - Resume for a master that is not pending is ignored.
  - A split and a resume for the same master on the same edge: the resume wins (flag stays 0).
- Both masters may be pending at once. Both requests masked → FSM stays IDLE.
- A preempted master keeps its request high and is re-granted after the other master releases. It gets no extra priority.
- Grants change only on clock edges. m1_grant and m2_grant are never both 1.

Optional Feature:
- ARB_ROUND_ROBIN_EN:
  - Defined: IDLE tie-break (both eff requests high, no resume-priority) goes to the master not granted most recently. The last-owner register resets to m2, so m1 wins the first tie.
  - Undefined: fixed priority, m1 always wins ties.

Test Plan:
- m1_request=1 alone → m1_grant=1 one cycle later. Drop request → grant 0 next cycle; TURN lasts 1 cycle; IDLE.
- m1 and m2 request in the same cycle, macro undefined → m1 granted. After m1 releases, m2 granted exactly 1 TURN cycle later. With macro defined, the second tie goes to m2.
- m1 granted, m2 requesting, m1 holds 40 cycles, MAX_HOLD=16 → m1_grant drops after 16 cycles; m2 granted 2 cycles later; m1 re-granted after m2 releases.
- m1 granted, slave_split pulse → m1_split_pending=1, m1 grant 0, m2 granted despite m1_request=1. split_resume with id=0 during m2's tenure → pending clears; m1 granted right after m2 releases, even if m2 requests again.
- Both masters split, neither resumed → FSM IDLE, bus_owner=0 with both requests high. Resume id=1 → m2 granted 1 cycle after IDLE evaluation.
- reset pulled low mid-GRANT_M2 → m2_grant, bus_owner and pending flags 0 without a clock edge. After release, m1 request granted normally.
